// File: rtl/ddr_req_seq.sv
// Purpose : programmable request sequencer feeding the DDR4 controller request port.
// Latency : start sampled at edge N -> first offer visible from edge N; one request per cycle when gap=0.
// Backpressure: offer (cmd_rdy/log_addr/request) is held stable until cmd_ack; no comb path ack->outputs.
//
// Ports:
//   CK_t, reset_n        clock (rising) / async active-low reset
//   start, abort         one-cycle launch pulse / synchronous stop
//   mode, base_addr,
//   stride, num_req,
//   gap, req_pattern     run configuration, captured on an accepted start
//   cmd_ack              controller accepts the current offer
//   cmd_rdy, log_addr,
//   request              registered request offer
//   busy, done,
//   issued_cnt           run status
module ddr_req_seq #(
  parameter int ADDR_W  = 40,
  parameter int REQ_W   = 3,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8
) (
  input  logic                     CK_t,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        stride,
  input  logic [CNT_W-1:0]         num_req,
  input  logic [GAP_W-1:0]         gap,
  input  logic [PAT_LEN*REQ_W-1:0] req_pattern,
  input  logic                     cmd_ack,
  output logic                     cmd_rdy,
  output logic [ADDR_W-1:0]        log_addr,
  output logic [REQ_W-1:0]         request,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         issued_cnt
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [1:0] MODE_INCR = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]               cfg_mode_q;
  logic [ADDR_W-1:0]        cfg_stride_q;
  logic [CNT_W-1:0]         cfg_num_q;
  logic [GAP_W-1:0]         cfg_gap_q;
  logic [PAT_LEN*REQ_W-1:0] cfg_pat_q;
  logic [IDX_W-1:0]         idx_q;
  logic [GAP_W-1:0]         gap_cnt_q;

  logic                     accept;
  logic                     launch;
  logic [CNT_W-1:0]         cnt_inc;
  logic [IDX_W-1:0]         idx_nxt;
  logic [ADDR_W-1:0]        addr_nxt;
  logic [ADDR_W-1:0]        seed;
  logic [REQ_W-1:0]         pat_slot [PAT_LEN];

  // cmd_rdy is only ever high in ISSUE, so this is the accept of the live offer.
  assign accept  = cmd_rdy & cmd_ack;
  assign launch  = (state_q == S_IDLE) & start;
  assign cnt_inc = issued_cnt + CNT_W'(1);

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  assign seed = ((mode == MODE_LFSR) && (base_addr == '0)) ? ADDR_W'(1) : base_addr;

  always_comb begin
    for (int k = 0; k < PAT_LEN; k++) begin
      pat_slot[k] = cfg_pat_q[k*REQ_W +: REQ_W];
    end
  end

  always_comb begin
    idx_nxt = idx_q + IDX_W'(1);
    if (idx_q == IDX_W'(PAT_LEN - 1)) begin
      idx_nxt = '0;
    end
  end

  always_comb begin
    addr_nxt = log_addr;
    case (cfg_mode_q)
      MODE_INCR: addr_nxt = log_addr + cfg_stride_q;
      MODE_LFSR: addr_nxt = {log_addr[ADDR_W-2:0], log_addr[ADDR_W-1] ^ log_addr[ADDR_W-2]};
      default:   addr_nxt = log_addr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_req != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          if (cnt_inc == cfg_num_q) begin
            state_d = S_DONE;
          end else if (cfg_gap_q == '0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything except IDLE; a coincident accept is still counted below.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cfg_mode_q   <= '0;
      cfg_stride_q <= '0;
      cfg_num_q    <= '0;
      cfg_gap_q    <= '0;
      cfg_pat_q    <= '0;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      cmd_rdy      <= 1'b0;
      log_addr     <= '0;
      request      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_cnt   <= '0;
    end else begin
      state_q <= state_d;
      cmd_rdy <= (state_d == S_ISSUE);
      busy    <= (state_d == S_ISSUE) || (state_d == S_GAP);
      done    <= (state_d == S_DONE);

      if (launch) begin
        cfg_mode_q   <= mode;
        cfg_stride_q <= stride;
        cfg_num_q    <= num_req;
        cfg_gap_q    <= gap;
        cfg_pat_q    <= req_pattern;
        idx_q        <= '0;
        issued_cnt   <= '0;
        log_addr     <= seed;
        request      <= req_pattern[REQ_W-1:0];
      end else if (accept) begin
        // Next offer is prepared here so it is already registered when ISSUE resumes.
        issued_cnt <= cnt_inc;
        idx_q      <= idx_nxt;
        log_addr   <= addr_nxt;
        request    <= pat_slot[idx_nxt];
        gap_cnt_q  <= cfg_gap_q;
      end else if (state_q == S_GAP) begin
        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr_req_seq.sv
// Purpose : self-checking bench for ddr_req_seq using a request scoreboard.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: cmd_ack driven per test (held low, tied high, or random).
module tb_ddr_req_seq;

  localparam int AW = 40;
  localparam int RW = 3;
  localparam int PL = 4;
  localparam int CW = 16;
  localparam int GW = 8;

  localparam logic [RW-1:0] WR  = 3'd1;
  localparam logic [RW-1:0] RDA = 3'd3;

  logic               CK_t = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [1:0]         mode = '0;
  logic [AW-1:0]      base_addr = '0;
  logic [AW-1:0]      stride = '0;
  logic [CW-1:0]      num_req = '0;
  logic [GW-1:0]      gap = '0;
  logic [PL*RW-1:0]   req_pattern = '0;
  logic               cmd_ack = 1'b0;
  logic               cmd_rdy;
  logic [AW-1:0]      log_addr;
  logic [RW-1:0]      request;
  logic               busy;
  logic               done;
  logic [CW-1:0]      issued_cnt;

  ddr_req_seq #(
    .ADDR_W (AW), .REQ_W (RW), .PAT_LEN (PL), .CNT_W (CW), .GAP_W (GW)
  ) dut (
    .CK_t        (CK_t),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .base_addr   (base_addr),
    .stride      (stride),
    .num_req     (num_req),
    .gap         (gap),
    .req_pattern (req_pattern),
    .cmd_ack     (cmd_ack),
    .cmd_rdy     (cmd_rdy),
    .log_addr    (log_addr),
    .request     (request),
    .busy        (busy),
    .done        (done),
    .issued_cnt  (issued_cnt)
  );

  always #5 CK_t = ~CK_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] typ;
  } exp_t;

  exp_t          exp_q [$];
  logic [AW-1:0] seen_q [$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            rdy_cnt = 0;
  int            low_run = 0;
  int            gap_n = 0;
  int            gap_min = 1000;
  int            gap_max = 0;

  logic [PL*RW-1:0] pat1 = {RDA, WR, RDA, WR};
  logic [PL*RW-1:0] pat2 = {3'd5, 3'd6, 3'd7, 3'd2};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference address step, written straight from the address rules.
  function automatic logic [AW-1:0] ref_next(input logic [1:0] m, input logic [AW-1:0] a,
                                             input logic [AW-1:0] s);
    case (m)
      2'd1:    return a + s;
      2'd2:    return {a[AW-2:0], a[AW-1] ^ a[AW-2]};
      default: return a;
    endcase
  endfunction

  // Scoreboard and activity monitor.
  always @(negedge CK_t) begin
    if (done) done_cnt++;
    if (cmd_rdy) rdy_cnt++;
    if (busy && !cmd_rdy) begin
      low_run++;
    end else if (cmd_rdy && low_run > 0) begin
      gap_n++;
      if (low_run < gap_min) gap_min = low_run;
      if (low_run > gap_max) gap_max = low_run;
      low_run = 0;
    end
    if (cmd_rdy && cmd_ack) begin
      seen_q.push_back(log_addr);
      if (exp_q.size() == 0) begin
        chk("sb_extra", cmd_rdy, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_addr", log_addr, mon_e.addr);
        chk("sb_type", request, mon_e.typ);
      end
    end
  end

  // Configures a run, pushes the expected accepted requests, pulses start.
  // Returns 1 time unit after the edge that samples start.
  task automatic launch(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input int n, input int g, input logic [PL*RW-1:0] p, input logic ack);
    logic [AW-1:0] a;
    logic [RW-1:0] slots [PL];
    @(posedge CK_t);
    #1;
    mode        = m;
    base_addr   = b;
    stride      = s;
    num_req     = CW'(n);
    gap         = GW'(g);
    req_pattern = p;
    cmd_ack     = ack;
    start       = 1'b1;
    done_cnt = 0; rdy_cnt = 0; low_run = 0; gap_n = 0; gap_min = 1000; gap_max = 0;
    seen_q.delete();
    for (int k = 0; k < PL; k++) slots[k] = p[k*RW +: RW];
    a = b;
    if (m == 2'd2 && a == '0) a = 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: a, typ: slots[i % PL]});
      a = ref_next(m, a, s);
    end
    @(posedge CK_t);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CK_t);
      if (done === 1'b1) break;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked while reset is still asserted.
    #3;
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_addr", log_addr, 0);
    chk("rst_req", request, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", issued_cnt, 0);
    #20;
    reset_n = 1'b1;

    // FIXED, back-to-back, ack tied high.
    launch(2'd0, 40'h17FD5, '0, 3, 0, pat1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CK_t);
      chk("fx_rdy", cmd_rdy, 1);
    end
    @(negedge CK_t);
    chk("fx_done", done, 1);
    chk("fx_rdy_low", cmd_rdy, 0);
    chk("fx_cnt", issued_cnt, 3);
    @(negedge CK_t);
    chk("fx_done_pulse", done, 0);
    chk("fx_busy", busy, 0);
    chk("fx_sb_left", exp_q.size(), 0);

    // INCR with gap of 2.
    launch(2'd1, 40'h100, 40'h40, 4, 2, pat1, 1'b1);
    wait_done("in_done", 100);
    chk("in_gap_n", gap_n, 3);
    chk("in_gap_min", gap_min, 2);
    chk("in_gap_max", gap_max, 2);
    chk("in_n_seen", seen_q.size(), 4);
    chk("in_a0", seen_q[0], 40'h100);
    chk("in_a1", seen_q[1], 40'h140);
    chk("in_a2", seen_q[2], 40'h180);
    chk("in_a3", seen_q[3], 40'h1C0);
    chk("in_cnt", issued_cnt, 4);

    // INCR wrap at 2^40.
    launch(2'd1, 40'hFF_FFFF_FFE0, 40'h40, 2, 0, pat1, 1'b1);
    wait_done("wr_done", 50);
    chk("wr_a1", seen_q[1], 40'h20);

    // LFSR from a zero seed.
    launch(2'd2, '0, '0, 3, 0, pat1, 1'b1);
    wait_done("lf0_done", 50);
    chk("lf0_a0", seen_q[0], 40'h1);
    chk("lf0_a1", seen_q[1], 40'h2);
    chk("lf0_a2", seen_q[2], 40'h4);

    // LFSR with feedback bit set.
    launch(2'd2, 40'h40_0000_0000, '0, 2, 0, pat1, 1'b1);
    wait_done("lf1_done", 50);
    chk("lf1_a1", seen_q[1], 40'h80_0000_0001);

    // Ack withheld for 5 cycles: offer must hold.
    launch(2'd0, 40'h2A0, '0, 1, 0, pat1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CK_t);
      chk("hold_rdy", cmd_rdy, 1);
      chk("hold_addr", log_addr, 40'h2A0);
      chk("hold_type", request, WR);
      chk("hold_cnt", issued_cnt, 0);
      @(posedge CK_t);
      #1;
    end
    cmd_ack = 1'b1;
    @(negedge CK_t);
    chk("hold_rdy6", cmd_rdy, 1);
    wait_done("hold_done", 20);
    chk("hold_cnt1", issued_cnt, 1);
    chk("hold_rdy_cycles", rdy_cnt, 6);

    // Abort coincident with the accept of request 2 of 5.
    launch(2'd1, 40'h1000, 40'h10, 5, 0, pat1, 1'b1);
    @(posedge CK_t);
    #1;
    abort = 1'b1;
    @(posedge CK_t);
    #1;
    abort = 1'b0;
    @(negedge CK_t);
    chk("ab_rdy", cmd_rdy, 0);
    chk("ab_busy", busy, 0);
    chk("ab_cnt", issued_cnt, 2);
    repeat (5) @(negedge CK_t);
    chk("ab_nodone", done_cnt, 0);
    chk("ab_sb_left", exp_q.size(), 3);
    exp_q.delete();

    // Reset pulsed while in GAP.
    launch(2'd1, 40'h500, 40'h8, 4, 5, pat1, 1'b1);
    @(posedge CK_t);
    #2;
    chk("rg_busy", busy, 1);
    chk("rg_rdy_gap", cmd_rdy, 0);
    reset_n = 1'b0;
    #1;
    chk("rg_rdy", cmd_rdy, 0);
    chk("rg_addr", log_addr, 0);
    chk("rg_req", request, 0);
    chk("rg_busy0", busy, 0);
    chk("rg_done", done, 0);
    chk("rg_cnt", issued_cnt, 0);
    @(negedge CK_t);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge CK_t);
    chk("rg_idle", busy, 0);

    // num_req = 0: done pulse only.
    launch(2'd0, 40'h77, '0, 0, 0, pat1, 1'b1);
    @(negedge CK_t);
    chk("z_done", done, 1);
    chk("z_rdy", cmd_rdy, 0);
    chk("z_busy", busy, 0);
    @(negedge CK_t);
    chk("z_done_pulse", done, 0);
    chk("z_rdy_cycles", rdy_cnt, 0);
    chk("z_cnt", issued_cnt, 0);

    // Pattern wrap over 7 requests with random ack and gap 1.
    launch(2'd1, 40'h3000, 40'h100, 7, 1, pat2, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(posedge CK_t);
      #1;
      cmd_ack = 1'($urandom_range(0, 1));
      if (done_cnt > 0) break;
    end
    chk("rnd_done", done_cnt, 1);
    chk("rnd_cnt", issued_cnt, 7);
    chk("rnd_sb_left", exp_q.size(), 0);
    chk("rnd_gap_min", gap_min, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
